pc_ctrl: RTL
============

# pc_ctrl

Next-PC sequencer for the fetch stage of the pipelined processor. Drives the `pc` modport inputs (`pcenable`, `pcnext`) of the program counter from instruction-memory handshake, hazard-unit stall, resolved branch/jump redirects and the halt signal. Holds a pending redirect across stalls, squashes the IF/ID latch on redirect, stops the PC permanently on halt, and counts PC advances for performance reporting.

## Interface
- `PC_STEP`, default 4: sequential increment added to `pcout`.
- `CLK`  in  1  system clock, all state on rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction fetch for current `pcout` completed this cycle.
- `stall`  in  1  hazard unit freezes the IF stage this cycle.
- `redirect`  in  1  taken branch/jump resolved this cycle.
- `redirect_addr`  in  32 (`word_t`)  target for `redirect`.
- `halt`  in  1  halt instruction has reached commit.
- `pcout`  in  32 (`word_t`)  current PC value, from the PC register.
- `pcenable`  out  1  PC register loads `pcnext` at the next edge.
- `pcnext`  out  32 (`word_t`)  value for the PC register.
- `flush`  out  1  squash IF/ID contents this cycle.
- `halted`  out  1  sticky halt indication.
- `fetch_count`  out  32  number of cycles with `pcenable` high since reset.

## Operation
- State register, 3 states: RUN, HOLD, HALTED. Registered `pend_addr` (32 bits), `fetch_count` (32 bits).
- `adv = ihit & ~stall`.
- Priority in every state: `halt` > `redirect` > sequential advance.
- RUN:
  - `halt`: `pcenable`=0, go HALTED.
  - `redirect & adv`: `pcenable`=1, `pcnext`=`redirect_addr`, `flush`=1, stay RUN.
  - `redirect & ~adv`: `pcenable`=0, `flush`=1, `pend_addr`<=`redirect_addr`, go HOLD.
  - `adv`, no redirect: `pcenable`=1, `pcnext`=`pcout`+`PC_STEP`.
  - Otherwise `pcenable`=0.
- HOLD:
  - `pcnext`=`pend_addr` by default.
  - `halt`: go HALTED, pending redirect discarded.
  - `redirect`: `flush`=1. If `adv`, load `redirect_addr` directly and go RUN. Otherwise overwrite `pend_addr` and stay in HOLD. The newest redirect always wins.
  - `adv`, no redirect: `pcenable`=1, `pcnext`=`pend_addr`, go RUN.
- HALTED:
  - `pcenable`=0, `flush`=0, `halted`=1.
  - Ignores all inputs until `nRST`.
- `pcnext` is don't-care when `pcenable`=0. It is driven `pcout`+`PC_STEP` in RUN and `pend_addr` in HOLD/HALTED.
- Arithmetic:
  - `pcout`+`PC_STEP` is 32-bit modulo: 0xFFFFFFFC+4 = 0x00000000.
  - `fetch_count` increments by 1 each cycle `pcenable`=1 and wraps 0xFFFFFFFF→0.

## Timing
- `pcenable`, `pcnext`, `flush` are combinational from inputs and state (same-cycle response). `halted` is decoded from the state register only.
- Redirect latency:
  - Redirect with `adv` loads the target into the PC at the same edge.
  - Redirect without `adv` loads at the first later edge with `adv` (and no newer redirect/halt).
- Halt latency: with `halt` high in cycle N, `pcenable`=0 in cycle N and `halted`=1 from cycle N+1.
- Reset (async, any time, including mid-HOLD):
  - State RUN, `pend_addr`=0, `fetch_count`=0, `halted`=0.
  - `pcenable`=0 and `flush`=0 while `nRST`=0.
  - Pending redirect lost.
- `stall` with `ihit`=1 never advances the PC. `ihit`=0 with `stall`=0 never advances.

## Test plan
- Sequential: reset, `pcout`=0x100, `ihit`=1 for 3 cycles → `pcenable`=1, `pcnext`=0x104 each cycle; `fetch_count`=3.
- Immediate redirect: RUN, `adv`=1, `redirect`=1, `redirect_addr`=0x2000 → `pcnext`=0x2000, `pcenable`=1, `flush`=1, state stays RUN.
- Held redirect: `stall`=1, `redirect`=0x3000 in cycle 0; `stall` for 2 more cycles → `pcenable`=0, `flush`=1 only in cycle 0. Release with `ihit`=1 → `pcnext`=0x3000, `pcenable`=1, back to RUN. Second redirect 0x4000 while in HOLD → 0x4000 loads instead.
- Halt priority: `halt`, `redirect` and `adv` all high → `pcenable`=0, `halted`=1 next cycle. Stays halted under further `ihit`/`redirect` until `nRST` pulse.
- Wrap: `pcout`=0xFFFFFFFC, `adv` → `pcnext`=0x00000000. Preload `fetch_count` to 0xFFFFFFFF by forcing, then one advance → 0.
- Async reset mid-HOLD: assert `nRST`=0 between edges → outputs low immediately. After release, `adv` gives `pcout`+4, not the old `pend_addr`.

Source files
------------

// File: rtl/pc_ctrl.sv
// Next-PC sequencer for the fetch stage: chooses between sequential advance,
// branch/jump redirect (immediate or held across stalls) and a sticky halt.
module pc_ctrl #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  input  logic [31:0] pcout,
  output logic        pcenable,
  output logic [31:0] pcnext,
  output logic        flush,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {RUN, HOLD, HALTED} state_t;

  state_t      state, state_nxt;
  logic        adv;
  logic        pend_ld;
  logic        en_raw, flush_raw;
  logic [31:0] pend_addr;
  logic [31:0] fcnt;

  assign adv = ihit & ~stall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  // HOLD exits on any advance; a redirect without an advance (re)captures the target
  always_comb begin
    state_nxt = state;
    pend_ld   = 1'b0;
    case (state)
      RUN: begin
        if (halt) state_nxt = HALTED;
        else if (redirect && !adv) begin
          state_nxt = HOLD;
          pend_ld   = 1'b1;
        end
      end
      HOLD: begin
        if (halt) state_nxt = HALTED;
        else if (redirect) begin
          if (adv) state_nxt = RUN;
          else     pend_ld   = 1'b1;
        end else if (adv) state_nxt = RUN;
      end
      default: state_nxt = HALTED;
    endcase
  end

  always_comb begin
    en_raw    = 1'b0;
    flush_raw = 1'b0;
    pcnext    = (state == RUN) ? pcout + PC_STEP : pend_addr;
    if (state != HALTED && !halt) begin
      if (redirect) begin
        flush_raw = 1'b1;
        en_raw    = adv;
        pcnext    = redirect_addr;
      end else begin
        en_raw = adv;
      end
    end
  end

  // Reset must silence the PC load and squash immediately, not at the next edge
  assign pcenable    = en_raw & nRST;
  assign flush       = flush_raw & nRST;
  assign halted      = (state == HALTED);
  assign fetch_count = fcnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend_addr <= '0;
      fcnt      <= '0;
    end else begin
      if (pend_ld)  pend_addr <= redirect_addr;
      if (pcenable) fcnt      <= fcnt + 32'd1;
    end
  end

endmodule
